// File: rtl/unary_pkg.sv
// Shared types for the unary stream decoder: FSM states and the decoded result record.
package unary_pkg;

  // Default binary operand width; the top module's BIN_BITS defaults to this.
  localparam int BIN_BITS_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Result record at the default width. The top derives its own copy for other widths.
  typedef struct packed {
    logic                  sat;
    logic [BIN_BITS_DEF:0] count;
  } result_t;

  // Packed width of a result record: sat bit plus a BIN_BITS+1 count.
  function automatic int res_w(input int bin_bits);
    return bin_bits + 2;
  endfunction

endpackage

// File: rtl/unary_result_fifo.sv
// Small synchronous FIFO for decoded results. Pop is ignored when empty; a push
// to a full FIFO is accepted only when a pop frees a slot in the same cycle.
module unary_result_fifo #(
  parameter int W          = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/unary_stream_decoder.sv
// Decodes a serial unary stream (burst of 1s closed by a 0 or flush) into a
// saturating binary count, buffering results in a small FIFO.
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter int BIN_BITS   = BIN_BITS_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  input  logic              flush,
  output logic [BIN_BITS:0] out_count,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              dropped
);

  localparam int                U_BITS = 2 ** BIN_BITS;
  localparam logic [BIN_BITS:0] U_MAX  = (BIN_BITS + 1)'(U_BITS);
  localparam int                W      = res_w(BIN_BITS);

  typedef struct packed {
    logic              sat;
    logic [BIN_BITS:0] count;
  } res_t;

  state_t            state;
  logic [BIN_BITS:0] cnt;
  logic              sat;
  logic              at_max;
  logic              push;
  res_t              push_res, head;
  logic [W-1:0]      head_bits;
  logic              full, empty;

  assign at_max = (cnt == U_MAX);

  // Decide whether this cycle closes a frame and what result it carries.
  always_comb begin
    push     = 1'b0;
    push_res = '0;
    case (state)
      IDLE: begin
        if (flush) begin
          push           = 1'b1;
          push_res.count = {{BIN_BITS{1'b0}}, in};
        end
      end
      COUNT: begin
        if (flush) begin
          // Current bit counts toward the closing frame, with saturation.
          push           = 1'b1;
          push_res.sat   = sat | (in & at_max);
          push_res.count = (in && !at_max) ? cnt + (BIN_BITS + 1)'(1) : cnt;
        end else if (!in) begin
          push           = 1'b1;
          push_res.sat   = sat;
          push_res.count = cnt;
        end
      end
      default: ;
    endcase
  end

  // Burst-counting FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && in) begin
            state <= COUNT;
            cnt   <= (BIN_BITS + 1)'(1);
          end
        end
        COUNT: begin
          if (flush || !in) begin
            state <= IDLE;
            cnt   <= '0;
            sat   <= 1'b0;
          end else if (at_max) begin
            sat <= 1'b1;
          end else begin
            cnt <= cnt + (BIN_BITS + 1)'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow flag: a result arrived with no room and no pop to make room.
  always_ff @(posedge clk) begin
    if (reset) dropped <= 1'b0;
    else if (push && full && !out_ready) dropped <= 1'b1;
  end

  unary_result_fifo #(
    .W          (W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_res),
    .pop       (out_ready),
    .pop_data  (head_bits),
    .full      (full),
    .empty     (empty)
  );

  assign head      = head_bits;
  assign out_valid = !empty;
  assign out_count = empty ? '0 : head.count;
  assign out_sat   = !empty && head.sat;
  assign busy      = (state == COUNT);

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Scoreboard bench for unary_stream_decoder (BIN_BITS=4, FIFO_DEPTH=2).
module tb_unary_stream_decoder;
  import unary_pkg::*;

  logic       clk = 1'b0;
  logic       reset, in, flush, out_ready;
  logic [4:0] out_count;
  logic       out_sat, out_valid, busy, dropped;

  result_t exp_q[$];
  int      vectors = 0;
  int      errors  = 0;
  int      valid_cycles = 0;

  unary_stream_decoder #(.BIN_BITS(4), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .flush     (flush),
    .out_count (out_count),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge and are sampled on the next one.
  task automatic drive(input logic i, input logic f, input logic r);
    @(posedge clk);
    #1;
    in = i; flush = f; out_ready = r;
  endtask

  task automatic expect_res(input int n, input logic s);
    result_t e;
    e.sat   = s;
    e.count = 5'(n);
    exp_q.push_back(e);
  endtask

  // n ones then a terminating 0; expected result is pushed unless told it will drop.
  task automatic burst(input int n, input logic r, input logic will_drop);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, r);
    if (!will_drop) expect_res((n > 16) ? 16 : n, n > 16);
    drive(1'b0, 1'b0, r);
  endtask

  // Monitor: compare head entry whenever it is being popped.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {out_sat, 26'd0, out_count}, 32'hFFFF_FFFF);
        end else begin
          result_t e;
          e = exp_q.pop_front();
          chk("out_count", out_count, e.count);
          chk("out_sat", out_sat, e.sat);
        end
      end else if (!out_valid) begin
        chk("zero_when_invalid", {out_sat, out_count}, 0);
      end
    end
  end

  initial begin
    reset = 1'b1; in = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_count", out_count, 0);
    reset = 1'b0;
    valid_cycles = 0;

    // Five ones: single-cycle valid with 5.
    burst(5, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    chk("valid_one_cycle", valid_cycles, 1);

    // Long burst saturates; exactly 16 does not.
    burst(20, 1'b1, 1'b0);
    burst(16, 1'b1, 1'b0);
    burst(17, 1'b1, 1'b0);

    // Idle flush gives zero.
    drive(1'b0, 1'b1, 1'b1);
    expect_res(0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk("idle_after_flush", busy, 0);

    // Back-to-back bursts separated by one 0.
    burst(2, 1'b1, 1'b0);
    burst(3, 1'b1, 1'b0);

    // Flush mid-burst with in=1 includes the current bit.
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk("busy_mid_burst", busy, 1);
    expect_res(4, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);

    // Overflow: 3 and 4 held, 2 dropped.
    burst(3, 1'b0, 1'b0);
    burst(4, 1'b0, 1'b0);
    burst(2, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    chk("dropped_set", dropped, 1);
    chk("full_valid", out_valid, 1);
    repeat (4) drive(1'b0, 1'b0, 1'b1);
    chk("drained_valid", out_valid, 0);
    chk("dropped_sticky", dropped, 1);

    // Reset mid-burst abandons partial count.
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in = 1'b0;
    chk("dropped_cleared", dropped, 0);
    burst(2, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b1);

    // Push into a full FIFO while popping is accepted.
    burst(1, 1'b0, 1'b0);
    burst(2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    expect_res(3, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("no_drop_with_pop", dropped, 0);

    // Bounded drain of anything still expected.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) drive(1'b0, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/unary_stream_decoder.md
UNARY_STREAM_DECODER -- requirements
Module: unary_stream_decoder

Interface
REQ-001 Parameter BIN_BITS, default 4, is the binary operand width; U_BITS = 2**BIN_BITS is the maximum unary burst length.
REQ-002 Parameter FIFO_DEPTH, default 2, is the number of decoded results buffered.
REQ-003 clk  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in  input  1  serial unary stream: a burst of contiguous 1s, terminated by a 0.
REQ-006 flush  input  1  forces the current frame to close this cycle; a flush while idle yields a zero result.
REQ-007 out_count  output  BIN_BITS+1  decoded burst length of the FIFO head entry.
REQ-008 out_sat  output  1  head entry saturated at U_BITS.
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 out_ready  input  1  consumer accepts the head entry when out_valid and out_ready are both high.
REQ-011 busy  output  1  a burst is being counted (state COUNT).
REQ-012 dropped  output  1  sticky flag: a result was lost because the FIFO was full.

Function
REQ-013 The FSM SHALL have two states: IDLE and COUNT.
REQ-014 IDLE, in=1, flush=0: cnt<=1, go to COUNT.
REQ-015 IDLE, in=0, flush=0: stay in IDLE, no push.
REQ-016 IDLE, flush=1: push {sat=0, count=in}, stay in IDLE.
REQ-017 COUNT, in=1, flush=0: cnt<=cnt+1, saturating at U_BITS; sat<=1 on any 1 sampled while cnt==U_BITS.
REQ-018 COUNT, in=0: push {sat, cnt}, go to IDLE, clear cnt and sat.
REQ-019 COUNT, flush=1: push {sat', cnt+in}, where the current bit is included with saturation applied; go to IDLE.
REQ-020 A single 0 is a sufficient separator between bursts; a 1 sampled in IDLE on the cycle after a terminating 0 SHALL start a new burst.
REQ-021 Latency: out_valid SHALL rise on the clock edge that samples the terminating 0 or flush, when the FIFO was empty.
REQ-022 A pop occurs when out_valid && out_ready; the FIFO SHALL keep its entries in first-in, first-out order.
REQ-023 A push to a full FIFO SHALL be accepted if a pop happens in the same cycle; otherwise the result is discarded, FIFO contents are unchanged, and dropped<=1.
REQ-024 A simultaneous push and pop on an empty FIFO is not a bypass: the push is stored and the pop is ignored, because out_valid is low.
REQ-025 out_count and out_sat SHALL be 0 whenever out_valid is 0.
REQ-026 dropped SHALL be cleared only by reset.

Reset
REQ-027 While reset is high: state=IDLE, cnt=0, sat=0, FIFO empty, out_valid=0, out_count=0, out_sat=0, busy=0, dropped=0.
REQ-028 Reset mid-burst SHALL abandon the partial count; counting restarts from the first 1 sampled after reset is low.
REQ-029 in, flush and out_ready SHALL be ignored in any cycle in which reset is high.

Structure
REQ-030 The FSM state enum and the result struct {sat, count} SHALL be defined in shared package unary_pkg, parameterised through BIN_BITS.
REQ-031 The buffer SHALL be a sub-module unary_result_fifo (depth FIFO_DEPTH, synchronous active-high reset, push/pop/full/empty); the decoder FSM SHALL sit in the top module.

Verification (BIN_BITS=4, FIFO_DEPTH=2)
REQ-032 in=1 for 5 cycles then 0, out_ready=1 -> out_valid is high for exactly 1 cycle, with out_count=5 and out_sat=0.
REQ-033 in=1 for 20 cycles then 0 -> out_count=16, out_sat=1.
REQ-034 flush pulse while IDLE with in=0 -> one result with out_count=0 and out_sat=0.
REQ-035 Stream 1,1,0,1,1,1,0 with out_ready=1 -> results 2 then 3, in order.
REQ-036 out_ready=0, bursts of length 3, 4 and 2 -> FIFO holds 3 and 4, dropped=1; then out_ready=1 -> pops yield 3 then 4, then out_valid=0.
REQ-037 Reset for 1 cycle after 3 ones, then 2 ones then 0 -> a single result with out_count=2; no result of 3 or 5 appears.
